// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program image from a byte source
// into a 128 x 32-bit instruction memory, holding the CPU in reset meanwhile.
// Stream format: one length byte L (word count N = L+1), then 4*N data bytes
// assembled little-endian into words written at addresses 0..N-1.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing 8-bit checksum
// byte (sum mod 256 of all data bytes) and drives o_err on mismatch.
module imem_loader (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_byteValid,
    input  logic [7:0]  i_byteData,
    output logic        o_byteReady,
    output logic        o_we,
    output logic [6:0]  o_waddr,
    output logic [31:0] o_wdata,
    output logic        o_cpuHold,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK  = 3'd3,
`endif
        ST_DONE = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [6:0]  r_waddr;
    logic [31:0] r_wdata;
    logic        r_cpuHold;
    logic        r_done;
    logic [1:0]  r_byteIdx;
    logic [23:0] r_assem;
    logic [6:0]  r_lastIdx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
    logic        r_err;
`endif

    logic        w_byteReady;
    logic        w_accept;

    // A byte is only taken while streaming, and never during the write-strobe
    // cycle, so a word is fully committed before the next one starts.
    always_comb begin
        w_byteReady = 1'b0;
        if ((r_state == ST_LEN) || (r_state == ST_DATA)
`ifdef LOADER_CHECKSUM_EN
            || (r_state == ST_CHK)
`endif
           ) begin
            w_byteReady = ~r_we;
        end
    end

    assign w_accept    = i_byteValid & w_byteReady;

    assign o_byteReady = w_byteReady;
    assign o_we        = r_we;
    assign o_waddr     = r_waddr;
    assign o_wdata     = r_wdata;
    assign o_cpuHold   = r_cpuHold;
    assign o_done      = r_done;
`ifdef LOADER_CHECKSUM_EN
    assign o_err       = r_err;
`else
    assign o_err       = 1'b0;
`endif

    // Loader FSM with registered outputs; reset wins over start and transfers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_waddr   <= 7'd0;
            r_wdata   <= 32'd0;
            r_cpuHold <= 1'b0;
            r_done    <= 1'b0;
            r_byteIdx <= 2'd0;
            r_assem   <= 24'd0;
            r_lastIdx <= 7'd0;
`ifdef LOADER_CHECKSUM_EN
            r_sum     <= 8'd0;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state   <= ST_LEN;
                        r_byteIdx <= 2'd0;
                        r_waddr   <= 7'd0;
                        r_done    <= 1'b0;
                        r_cpuHold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        r_sum     <= 8'd0;
                        r_err     <= 1'b0;
`endif
                    end
                end

                ST_LEN: begin
                    if (w_accept) begin
                        // L is limited to 0..127, so the low seven bits are the last word index.
                        r_lastIdx <= i_byteData[6:0];
                        r_state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (r_we) begin
                        r_we <= 1'b0;
                        if (r_waddr == r_lastIdx) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state   <= ST_CHK;
`else
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_cpuHold <= 1'b0;
`endif
                        end else begin
                            r_waddr <= r_waddr + 7'd1;
                        end
                    end else if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
                        r_sum <= r_sum + i_byteData;
`endif
                        r_byteIdx <= r_byteIdx + 2'd1;
                        case (r_byteIdx)
                            2'd0:    r_assem[7:0]   <= i_byteData;
                            2'd1:    r_assem[15:8]  <= i_byteData;
                            2'd2:    r_assem[23:16] <= i_byteData;
                            default: begin
                                r_wdata <= {i_byteData, r_assem};
                                r_we    <= 1'b1;
                            end
                        endcase
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (w_accept) begin
                        r_err     <= (i_byteData != r_sum);
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_cpuHold <= 1'b0;
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed scenarios plus randomized loads checked
// against a byte-stream reference model (words, addresses, checksum).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byteValid;
    logic [7:0]  byteData;
    logic        byteReady;
    logic        we;
    logic [6:0]  waddr;
    logic [31:0] wdata;
    logic        cpuHold;
    logic        done;
    logic        err;

    int checkCount = 0;
    int errorCount = 0;

    logic [6:0]  capAddr[$];
    logic [31:0] capData[$];
    logic [7:0]  stimBytes[$];

    imem_loader dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_byteValid (byteValid),
        .i_byteData  (byteData),
        .o_byteReady (byteReady),
        .o_we        (we),
        .o_waddr     (waddr),
        .o_wdata     (wdata),
        .o_cpuHold   (cpuHold),
        .o_done      (done),
        .o_err       (err)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Record every memory write mid-cycle; the loader must not take a byte while writing.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            capAddr.push_back(waddr);
            capData.push_back(wdata);
            checkOutput("readyLowOnWe", {31'd0, byteReady}, 32'd0);
        end
    end

    // Offer one byte and hold it until a clock edge where the loader is ready.
    // mode 0: continuous valid, 1: one idle cycle before each byte, 2: random idle.
    task automatic sendByte(input logic [7:0] b, input int mode);
        int  waitCount = 0;
        bit  accepted  = 0;
        if ((mode == 1) || ((mode == 2) && ($urandom_range(0, 1) == 1))) begin
            byteValid = 1'b0;
            byteData  = 8'h5A;
            @(posedge clk); #1;
        end
        byteValid = 1'b1;
        byteData  = b;
        while (!accepted && (waitCount < 50)) begin
            @(negedge clk);
            accepted = (byteReady === 1'b1);
            @(posedge clk); #1;
            waitCount++;
        end
        byteValid = 1'b0;
        if (!accepted) checkOutput("byteAcceptTimeout", 32'd0, 32'd1);
    endtask

    task automatic pulseStart();
        // A bogus byte offered alongside start must not be consumed in IDLE/DONE.
        start     = 1'b1;
        byteValid = 1'b1;
        byteData  = 8'hEE;
        @(posedge clk); #1;
        start     = 1'b0;
        byteValid = 1'b0;
    endtask

    // Full load of length byte L and data in stimBytes, then compare against the model.
    task automatic applyStimulus(input int lenByte, input logic [7:0] chk, input int mode, input bit midStart);
        int          nWords;
        int          t;
        int unsigned word;
        int unsigned sum;
        bit          expErr;
        capAddr.delete();
        capData.delete();
        pulseStart();
        checkOutput("holdAfterStart", {31'd0, cpuHold}, 32'd1);
        checkOutput("doneClearedOnStart", {31'd0, done}, 32'd0);
        sendByte(lenByte[7:0], mode);
        if (midStart) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        foreach (stimBytes[i]) sendByte(stimBytes[i], mode);
`ifdef LOADER_CHECKSUM_EN
        sendByte(chk, mode);
`endif
        t = 0;
        while ((done !== 1'b1) && (t < 20)) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("doneHigh", {31'd0, done}, 32'd1);
        checkOutput("holdReleased", {31'd0, cpuHold}, 32'd0);
        checkOutput("readyLowInDone", {31'd0, byteReady}, 32'd0);
        checkOutput("weLowInDone", {31'd0, we}, 32'd0);

        // Reference model: N = L+1 words, little-endian bytes, sum mod 256.
        nWords = lenByte + 1;
        sum    = 0;
        foreach (stimBytes[i]) sum = (sum + stimBytes[i]) % 256;
`ifdef LOADER_CHECKSUM_EN
        expErr = (sum != chk);
`else
        expErr = 0;
`endif
        checkOutput("writeCount", capAddr.size(), nWords);
        word = 0;
        for (int i = 0; i < nWords; i++) begin
            word = stimBytes[4*i] + 256 * stimBytes[4*i+1]
                 + 65536 * stimBytes[4*i+2] + 16777216 * stimBytes[4*i+3];
            if (i < capAddr.size()) begin
                checkOutput($sformatf("waddr[%0d]", i), {25'd0, capAddr[i]}, i);
                checkOutput($sformatf("wdata[%0d]", i), capData[i], word);
            end
        end
        checkOutput("finalWaddr", {25'd0, waddr}, nWords - 1);
        checkOutput("finalWdata", wdata, word);
        checkOutput("errFlag", {31'd0, err}, {31'd0, expErr});
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".byteReady"}, {31'd0, byteReady}, 32'd0);
        checkOutput({tag, ".we"}, {31'd0, we}, 32'd0);
        checkOutput({tag, ".waddr"}, {25'd0, waddr}, 32'd0);
        checkOutput({tag, ".wdata"}, wdata, 32'd0);
        checkOutput({tag, ".cpuHold"}, {31'd0, cpuHold}, 32'd0);
        checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, ".err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int          lenByte;
        int unsigned sum;
        logic [7:0]  chk;

        rst       = 1'b1;
        start     = 1'b0;
        byteValid = 1'b0;
        byteData  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-word load: 00, 13 00 00 00.
        $display("[TB] single word load");
        stimBytes = '{8'h13, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 8'h13, 0, 0);

        // Full 128-word load with incrementing byte data.
        $display("[TB] full 128-word load");
        stimBytes.delete();
        for (int i = 0; i < 512; i++) stimBytes.push_back(i[7:0]);
        applyStimulus(127, 8'h00, 0, 0);

        // Two-word load with valid toggled every other cycle.
        $display("[TB] two words with gapped valid");
        stimBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        applyStimulus(1, 8'h64, 1, 0);

        // Reset after six data bytes aborts the load.
        $display("[TB] reset mid-load");
        capAddr.delete();
        capData.delete();
        pulseStart();
        sendByte(8'd3, 0);
        for (int i = 0; i < 6; i++) sendByte(8'hA0 + i[7:0], 0);
        checkOutput("writesBeforeAbort", capAddr.size(), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkResetOutputs("abort");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("noWriteAfterAbort", capAddr.size(), 1);
        checkOutput("idleAfterAbort", {31'd0, cpuHold}, 32'd0);

        // Reset takes priority over a simultaneous start and byte.
        rst       = 1'b1;
        start     = 1'b1;
        byteValid = 1'b1;
        byteData  = 8'h02;
        @(posedge clk); #1;
        rst       = 1'b0;
        start     = 1'b0;
        byteValid = 1'b0;
        checkOutput("rstBeatsStart", {31'd0, cpuHold}, 32'd0);
        @(posedge clk); #1;
        checkOutput("stillIdle", {31'd0, cpuHold}, 32'd0);

        // Fresh load after the abort starts again at address 0.
        $display("[TB] fresh load after abort");
        stimBytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(1, 8'h00, 0, 0);

        // Checksum pair: 01 02 03 04 sums to 0x0A.
        $display("[TB] checksum good and bad");
        stimBytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(0, 8'h0A, 0, 0);
        applyStimulus(0, 8'h0B, 0, 0);

        // Randomized loads with random gaps, ignored mid-load starts and checksums.
        $display("[TB] randomized loads");
        for (int r = 0; r < 8; r++) begin
            lenByte = $urandom_range(0, 12);
            stimBytes.delete();
            sum = 0;
            for (int i = 0; i < 4 * (lenByte + 1); i++) begin
                stimBytes.push_back($urandom_range(0, 255));
                sum = (sum + stimBytes[i]) % 256;
            end
            chk = ($urandom_range(0, 1) == 1) ? sum[7:0] : 8'($urandom_range(0, 255));
            applyStimulus(lenByte, chk, 2, ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  single-cycle pulse to begin a load; honoured only in IDLE or DONE.
REQ-004 byte_valid  input  1  byte source has byte_data available.
REQ-005 byte_data  input  8  incoming program byte.
REQ-006 byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
REQ-007 we  output  1  one-cycle write strobe to the instruction memory write port.
REQ-008 waddr  output  7  word address, 0..127, matching the 128-entry x 32-bit instruction memory.
REQ-009 wdata  output  32  assembled instruction word.
REQ-010 cpu_hold  output  1  high while a load is in progress; the CPU core is held in reset by it.
REQ-011 done  output  1  level, high after a complete load until the next start or rst.
REQ-012 err  output  1  checksum mismatch flag; valid when done=1.

Function
REQ-013 FSM states: IDLE, LEN, DATA, CHK, DONE.
REQ-014 IDLE/DONE + start -> LEN; clears byte index, waddr, running sum, done, err; sets cpu_hold=1.
REQ-015 byte_ready=1 only in LEN, DATA, CHK; 0 in IDLE, DONE and the cycle we=1.
REQ-016 LEN: accepted byte L stored; word count N = L+1 (1..128); -> DATA.
REQ-017 DATA: bytes assembled little-endian: 1st byte -> wdata[7:0], 4th -> wdata[31:24].
REQ-018 On acceptance of the 4th byte of a word, we=1 exactly one cycle later, with waddr = word index and wdata = that word; no byte accepted during that cycle.
REQ-019 waddr increments by 1 the cycle after each we pulse; never exceeds N-1; no wrap within one load.
REQ-020 After write of word N-1: -> CHK if LOADER_CHECKSUM_EN is defined, else -> DONE.
REQ-021 DONE: done=1, cpu_hold=0, byte_ready=0; wdata and waddr hold last values; we=0.
REQ-022 start while in LEN, DATA or CHK is ignored.
REQ-023 byte_valid low in any accepting state stalls the FSM indefinitely with no output change.
REQ-024 start and byte_valid in the same IDLE cycle: byte is not accepted (byte_ready=0 in IDLE).

Reset
REQ-025 rst=1 at a clock edge: state=IDLE, byte_ready=0, we=0, waddr=0, wdata=0, cpu_hold=0, done=0, err=0.
REQ-026 rst mid-load aborts immediately; words already written stay in memory; a pending we is not issued.
REQ-027 rst has priority over start and byte transfers in the same cycle.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN.
REQ-029 Defined: loader keeps an 8-bit sum (mod 256) of all DATA bytes; CHK accepts one byte; err=1 if it differs from the sum, else 0; -> DONE.
REQ-030 Not defined: CHK state and sum logic are absent; no trailing byte is consumed; err is tied to 0.

Verification
REQ-031 start; bytes 00, 13,00,00,00 -> one we pulse, waddr=0, wdata=0x00000013; done=1, cpu_hold=0.
REQ-032 L=0x7F, 512 bytes of incrementing word data -> 128 we pulses, waddr 0..127 in order, final done=1, waddr=127.
REQ-033 L=0x01, byte_valid toggled every other cycle -> same two words written as with continuous valid; byte_ready=0 on each we cycle.
REQ-034 rst asserted after 6 data bytes -> next cycle all outputs at reset values; no further we; fresh start then loads correctly from waddr=0.
REQ-035 With LOADER_CHECKSUM_EN: L=00, bytes 01,02,03,04, check byte 0x0A -> err=0; same with check 0x0B -> err=1; without the macro the loader reaches DONE after the 4th byte with err=0.
